proj_tile_ctrl: RTL and testbench
=================================

// Module: proj_tile_ctrl
// PURPOSE
//  Parametrised tiled-projection sequencer for the self-attention block; generalises the Q projection controller to Q/K/V modes.
//  Streams input-row and weight tiles from SRAM into an external NxN systolic array, accumulates over K_TILES inner tiles,
//  then writes each NxN result tile to output SRAM row by row. Runs OUT_TILES output tiles per start; start/busy/done/abort control.
// PARAMETERS
//  N         4    systolic array dimension (tile is NxN)
//  DATA_W    8    operand element width
//  ACC_W     32   accumulator element width; output row = N*ACC_W bits
//  K_TILES   32   inner-dimension tiles accumulated per output tile
//  OUT_TILES 32   output tiles per run
//  IN_AW     5    input SRAM address width (>= clog2(K_TILES))
//  W_AW      12   weight SRAM address width (>= clog2(3*K_TILES*OUT_TILES))
//  OUT_AW    7    output SRAM address width (>= clog2(OUT_TILES*N))
// PORTS
//  clk          in   1              clock
//  rst          in   1              asynchronous reset, active-high
//  start        in   1              begin run; sampled in IDLE only
//  mode         in   2              0=Q 1=K 2=V (3 reserved: treated as 0); latched at start
//  abort        in   1              terminate run, return to IDLE
//  busy         out  1              high in every state except IDLE
//  done         out  1              1-cycle pulse at end of complete run
//  in_ceb/in_web   out 1/1          input SRAM chip enable / write enable, active-low (web always 1)
//  in_addr      out  IN_AW          input SRAM address
//  in_dout      in   N*N*DATA_W     input SRAM read data (1-cycle read latency)
//  w_ceb/w_web  out  1/1            weight SRAM enables, active-low (web always 1)
//  w_addr       out  W_AW           weight SRAM address
//  w_dout       in   N*N*DATA_W     weight SRAM read data (1-cycle read latency)
//  out_ceb/out_web out 1/1          output SRAM enables, active-low
//  out_addr     out  OUT_AW         output SRAM address
//  out_din      out  N*ACC_W        output SRAM write data
//  sa_clr       out  1              clear array accumulators
//  sa_a/sa_b    out  N*N*DATA_W     operands to array (= in_dout / w_dout passthrough)
//  sa_in_valid  out  1              operands valid this cycle (1-cycle pulse)
//  sa_step_done in   1              array finished accumulating last operand pair
//  sa_result    in   N*N*ACC_W      accumulated tile; row r = bits [(r+1)*N*ACC_W-1 : r*N*ACC_W]
// BEHAVIOUR
//  Reset: state=IDLE, k=o=r=0, mode_q=0; all ceb/web=1, sa_clr=sa_in_valid=done=busy=0, addresses=0, out_din=0.
//  Counters k (0..K_TILES-1), o (0..OUT_TILES-1), r (0..N-1) are registered; addresses decode from registers:
//   in_addr=k; w_addr=mode_q*K_TILES*OUT_TILES + k*OUT_TILES + o; out_addr=o*N+r; out_din=sa_result row r.
//  FSM: IDLE -start-> CLR (latch mode, k=o=r=0).
//   CLR: sa_clr=1 one cycle -> RD.
//   RD: in_ceb=w_ceb=0 -> FEED.
//   FEED: sa_in_valid=1 (SRAM data valid this cycle) -> WAIT.
//   WAIT: hold until sa_step_done; then k<K_TILES-1: k++ -> RD; k==K_TILES-1: k=0, r=0 -> WR.
//   WR: out_ceb=out_web=0 each cycle, r++; after r==N-1: o<OUT_TILES-1: o++ -> CLR; o==OUT_TILES-1 -> DONE.
//   DONE: done=1 one cycle, o=0 -> IDLE.
//  Latency per output tile (array step latency L cycles after sa_in_valid): 1 + K_TILES*(2+L) + N cycles.
//  sa_step_done outside WAIT ignored; in same cycle as sa_in_valid counts only if state==WAIT (it cannot be).
//  start while busy ignored; start and abort together in IDLE: abort wins, stays IDLE.
//  abort in any non-IDLE state: next cycle IDLE, counters cleared, no done, no further SRAM access; a WR in progress is truncated.
//  rst mid-run: immediate IDLE, all outputs to reset values; no partial-tile completion.
//  Output writes only in WR; input/weight SRAMs never written.
// TESTING (bench: N=4, K_TILES=2, OUT_TILES=2, array model with L=3, SRAM models)
//  Mode Q, start pulse -> w_addr seq 0,2,1,3; in_addr 0,1,0,1; out_addr 0..7; done once at cycle 1+2*(1+2*5+4)=31 after start.
//  Mode V -> w_addr seq 8,10,9,11; results match golden A*W_V per tile; mode 3 behaves as mode 0.
//  Identity weights, input tile rows all 1..16 -> out_din rows equal 2x input rows (sum of 2 k-tiles), written to addr o*4+r.
//  abort asserted during second WR cycle -> out_ceb high next cycle, busy=0, done never pulses; new start runs cleanly from o=0.
//  start pulsed while busy and spurious sa_step_done in RD/FEED -> no effect on address sequence or done timing.
//  rst asserted mid-WAIT -> all ceb/web=1, busy=0 same cycle (async), counters 0; subsequent run matches golden.

Source files
------------

// File: rtl/proj_tile_ctrl.sv
// rtl/proj_tile_ctrl.sv - Tiled Q/K/V projection sequencer driving an external NxN systolic array
module proj_tile_ctrl #(
    parameter int N         = 4,
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 32,
    parameter int K_TILES   = 32,
    parameter int OUT_TILES = 32,
    parameter int IN_AW     = 5,
    parameter int W_AW      = 12,
    parameter int OUT_AW    = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    in_ceb,
    output logic                    in_web,
    output logic [IN_AW-1:0]        in_addr,
    input  logic [N*N*DATA_W-1:0]   in_dout,
    output logic                    w_ceb,
    output logic                    w_web,
    output logic [W_AW-1:0]         w_addr,
    input  logic [N*N*DATA_W-1:0]   w_dout,
    output logic                    out_ceb,
    output logic                    out_web,
    output logic [OUT_AW-1:0]       out_addr,
    output logic [N*ACC_W-1:0]      out_din,
    output logic                    sa_clr,
    output logic [N*N*DATA_W-1:0]   sa_a,
    output logic [N*N*DATA_W-1:0]   sa_b,
    output logic                    sa_in_valid,
    input  logic                    sa_step_done,
    input  logic [N*N*ACC_W-1:0]    sa_result
);
    localparam int KW = (K_TILES > 1) ? $clog2(K_TILES) : 1;
    localparam int OW = (OUT_TILES > 1) ? $clog2(OUT_TILES) : 1;
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(K_TILES - 1);
    localparam logic [OW-1:0] O_LAST = OW'(OUT_TILES - 1);
    localparam logic [RW-1:0] R_LAST = RW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RD,
        S_FEED,
        S_WAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic [OW-1:0]   o;
    logic [RW-1:0]   r;
    logic [1:0]      mode_q;

    assign in_web  = 1'b1;
    assign w_web   = 1'b1;
    assign sa_a    = in_dout;
    assign sa_b    = w_dout;

    // Weight bank per mode: K_TILES*OUT_TILES tiles, k-major then output tile.
    assign in_addr  = IN_AW'(k);
    assign w_addr   = W_AW'(mode_q) * W_AW'(K_TILES * OUT_TILES)
                    + W_AW'(k) * W_AW'(OUT_TILES) + W_AW'(o);
    assign out_addr = OUT_AW'(o) * OUT_AW'(N) + OUT_AW'(r);
    assign out_din  = (state == S_WR) ? sa_result[int'(r)*N*ACC_W +: N*ACC_W] : '0;

    // Control outputs are registered: each is loaded on the transition into the state that owns it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            k           <= '0;
            o           <= '0;
            r           <= '0;
            mode_q      <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            in_ceb      <= 1'b1;
            w_ceb       <= 1'b1;
            out_ceb     <= 1'b1;
            out_web     <= 1'b1;
            sa_clr      <= 1'b0;
            sa_in_valid <= 1'b0;
        end else begin
            done        <= 1'b0;
            in_ceb      <= 1'b1;
            w_ceb       <= 1'b1;
            out_ceb     <= 1'b1;
            out_web     <= 1'b1;
            sa_clr      <= 1'b0;
            sa_in_valid <= 1'b0;
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                k     <= '0;
                o     <= '0;
                r     <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state  <= S_CLR;
                            mode_q <= (mode == 2'd3) ? 2'd0 : mode;
                            k      <= '0;
                            o      <= '0;
                            r      <= '0;
                            busy   <= 1'b1;
                            sa_clr <= 1'b1;
                        end
                    end
                    S_CLR: begin
                        state  <= S_RD;
                        in_ceb <= 1'b0;
                        w_ceb  <= 1'b0;
                    end
                    S_RD: begin
                        state       <= S_FEED;
                        sa_in_valid <= 1'b1;
                    end
                    S_FEED: begin
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (sa_step_done) begin
                            if (k != K_LAST) begin
                                k      <= k + 1'b1;
                                state  <= S_RD;
                                in_ceb <= 1'b0;
                                w_ceb  <= 1'b0;
                            end else begin
                                k       <= '0;
                                r       <= '0;
                                state   <= S_WR;
                                out_ceb <= 1'b0;
                                out_web <= 1'b0;
                            end
                        end
                    end
                    S_WR: begin
                        if (r == R_LAST) begin
                            r <= '0;
                            if (o != O_LAST) begin
                                o      <= o + 1'b1;
                                state  <= S_CLR;
                                sa_clr <= 1'b1;
                            end else begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            r       <= r + 1'b1;
                            out_ceb <= 1'b0;
                            out_web <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        o     <= '0;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_proj_tile_ctrl.sv
// tb/tb_proj_tile_ctrl.sv - Randomized self-checking bench for proj_tile_ctrl
module tb_proj_tile_ctrl;
    localparam int N = 4, DATA_W = 8, ACC_W = 32, KT = 2, OT = 2;
    localparam int IN_AW = 5, W_AW = 12, OUT_AW = 7, L = 3;
    localparam int TW = N*N*DATA_W, RWID = N*ACC_W, RESW = N*N*ACC_W;

    logic clk = 0, rst = 1, start = 0, abort = 0, spur = 0;
    logic [1:0] mode = 0;
    logic busy, done, in_ceb, in_web, w_ceb, w_web, out_ceb, out_web;
    logic sa_clr, sa_in_valid, sa_step_done;
    logic [IN_AW-1:0] in_addr;
    logic [W_AW-1:0] w_addr;
    logic [OUT_AW-1:0] out_addr;
    logic [RWID-1:0] out_din;
    logic [TW-1:0] in_dout = '0, w_dout = '0, sa_a, sa_b;
    logic [RESW-1:0] sa_result, acc;
    int acnt;

    logic [TW-1:0] in_mem [0:31];
    logic [TW-1:0] w_mem [0:15];
    int rd_in_q[$], rd_w_q[$], wr_addr_q[$];
    logic [RWID-1:0] wr_data_q[$];
    int cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
    int n_cmp = 0, n_err = 0;

    proj_tile_ctrl #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_TILES(KT), .OUT_TILES(OT),
                     .IN_AW(IN_AW), .W_AW(W_AW), .OUT_AW(OUT_AW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .busy(busy), .done(done),
        .in_ceb(in_ceb), .in_web(in_web), .in_addr(in_addr), .in_dout(in_dout),
        .w_ceb(w_ceb), .w_web(w_web), .w_addr(w_addr), .w_dout(w_dout),
        .out_ceb(out_ceb), .out_web(out_web), .out_addr(out_addr), .out_din(out_din),
        .sa_clr(sa_clr), .sa_a(sa_a), .sa_b(sa_b), .sa_in_valid(sa_in_valid),
        .sa_step_done(sa_step_done), .sa_result(sa_result)
    );

    always #5 clk = ~clk;

    function automatic int unsigned el(input logic [TW-1:0] t, input int i, input int j);
        return int'(t[(i*N+j)*DATA_W +: DATA_W]);
    endfunction

    function automatic logic [RESW-1:0] mac(input logic [RESW-1:0] a0, input logic [TW-1:0] a,
                                            input logic [TW-1:0] b);
        logic [RESW-1:0] res = a0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int unsigned s = res[(i*N+j)*ACC_W +: ACC_W];
                for (int t = 0; t < N; t++) s += el(a, i, t) * el(b, t, j);
                res[(i*N+j)*ACC_W +: ACC_W] = s;
            end
        return res;
    endfunction

    // Golden row r of output tile o: sum over k of A_k * W[mode bank][k][o].
    function automatic logic [RWID-1:0] exp_row(input int m, input int o, input int r);
        logic [RWID-1:0] row = '0;
        for (int c = 0; c < N; c++) begin
            int unsigned s = 0;
            for (int k = 0; k < KT; k++)
                for (int j = 0; j < N; j++)
                    s += el(in_mem[k], r, j) * el(w_mem[m*KT*OT + k*OT + o], j, c);
            row[c*ACC_W +: ACC_W] = s;
        end
        return row;
    endfunction

    always @(posedge clk) begin
        if (!in_ceb) in_dout <= in_mem[in_addr];
        if (!w_ceb) w_dout <= w_mem[w_addr[3:0]];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            acnt <= 0;
        end else begin
            if (sa_clr) acc <= '0;
            else if (sa_in_valid) acc <= mac(acc, sa_a, sa_b);
            if (sa_in_valid) acnt <= L;
            else if (acnt != 0) acnt <= acnt - 1;
        end
    end
    assign sa_step_done = (acnt == 1) || spur;
    assign sa_result = acc;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!in_ceb) rd_in_q.push_back(int'(in_addr));
        if (!w_ceb) rd_w_q.push_back(int'(w_addr));
        if (!out_ceb && !out_web) begin
            wr_addr_q.push_back(int'(out_addr));
            wr_data_q.push_back(out_din);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (start && !abort && !busy && !rst) start_cyc <= cyc;
    end

    task automatic chk(input string tag, input logic [RWID-1:0] obs, input logic [RWID-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_in_q.delete();
        rd_w_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic randomize_mems();
        for (int i = 0; i < 32; i++) in_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 16; i++) w_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic run_check(input logic [1:0] m, input string tag, input bit spurious);
        int base, em;
        em = (m == 2'd3) ? 0 : int'(m);
        clear_logs();
        base = done_cnt;
        @(negedge clk);
        mode = m;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 200 && done_cnt == base; i++) begin
            spur = spurious && (in_ceb == 1'b0 || sa_in_valid == 1'b1);
            start = spurious && (i % 7 == 3);
            @(negedge clk);
        end
        start = 0;
        spur = 0;
        chk({tag, " done_count"}, done_cnt - base, 1);
        chk({tag, " done_latency"}, done_cyc - start_cyc, 1 + OT*(1 + KT*(2+L) + N));
        chk({tag, " rd_in_count"}, rd_in_q.size(), KT*OT);
        chk({tag, " rd_w_count"}, rd_w_q.size(), KT*OT);
        chk({tag, " wr_count"}, wr_addr_q.size(), OT*N);
        for (int o = 0; o < OT; o++)
            for (int k = 0; k < KT; k++) begin
                int idx = o*KT + k;
                chk($sformatf("%s in_addr[%0d]", tag, idx),
                    (idx < rd_in_q.size()) ? rd_in_q[idx] : -1, k);
                chk($sformatf("%s w_addr[%0d]", tag, idx),
                    (idx < rd_w_q.size()) ? rd_w_q[idx] : -1, em*KT*OT + k*OT + o);
            end
        for (int o = 0; o < OT; o++)
            for (int r = 0; r < N; r++) begin
                int idx = o*N + r;
                chk($sformatf("%s out_addr[%0d]", tag, idx),
                    (idx < wr_addr_q.size()) ? wr_addr_q[idx] : -1, o*N + r);
                chk($sformatf("%s out_din[%0d]", tag, idx),
                    (idx < wr_data_q.size()) ? wr_data_q[idx] : '1, exp_row(em, o, r));
            end
        @(negedge clk);
        chk({tag, " idle_after"}, busy, 0);
    endtask

    initial begin
        logic [RWID-1:0] row;
        randomize_mems();
        repeat (3) @(negedge clk);
        chk("rst in_ceb", in_ceb, 1);
        chk("rst w_ceb", w_ceb, 1);
        chk("rst out_ceb", out_ceb, 1);
        chk("rst webs", {in_web, w_web, out_web}, 3'b111);
        chk("rst busy_done", {busy, done}, 0);
        chk("rst sa_ctrl", {sa_clr, sa_in_valid}, 0);
        chk("rst addrs", {in_addr, w_addr, out_addr}, 0);
        chk("rst out_din", out_din, 0);
        rst = 0;
        @(negedge clk);

        // Identity weights, input rows 1..16: each output row is twice the input row.
        for (int k = 0; k < KT; k++)
            for (int i = 0; i < N*N; i++) in_mem[k][i*DATA_W +: DATA_W] = DATA_W'(i + 1);
        for (int t = 0; t < 16; t++)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) w_mem[t][(i*N+j)*DATA_W +: DATA_W] = DATA_W'(i == j);
        run_check(2'd0, "ident", 0);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) row[c*ACC_W +: ACC_W] = ACC_W'(2*(r*N + c + 1));
            chk($sformatf("ident row%0d", r), (r < wr_data_q.size()) ? wr_data_q[r] : '1, row);
        end

        randomize_mems();
        run_check(2'd0, "modeQ", 0);
        run_check(2'd2, "modeV", 0);
        run_check(2'd3, "mode3", 0);
        run_check(2'd1, "spur", 1);

        // start and abort together in IDLE
        @(negedge clk);
        start = 1;
        abort = 1;
        @(negedge clk);
        start = 0;
        abort = 0;
        chk("start_abort busy", busy, 0);

        // abort during the second WR cycle
        begin
            int base, seen, wrs;
            randomize_mems();
            clear_logs();
            base = done_cnt;
            start = 1;
            @(negedge clk);
            start = 0;
            seen = 0;
            for (int i = 0; i < 100 && seen < 2; i++) begin
                @(negedge clk);
                if (!out_ceb) seen++;
            end
            chk("abort reached_wr2", seen, 2);
            abort = 1;
            @(negedge clk);
            abort = 0;
            chk("abort out_ceb", out_ceb, 1);
            chk("abort busy", busy, 0);
            wrs = wr_addr_q.size();
            chk("abort writes", wrs, 2);
            repeat (40) @(negedge clk);
            chk("abort no_done", done_cnt - base, 0);
            chk("abort no_more_wr", wr_addr_q.size(), wrs);
            chk("abort no_rd", rd_in_q.size(), KT);
        end
        run_check(2'd1, "post_abort", 0);

        // async reset in WAIT of the second k step
        begin
            int seen = 0;
            mode = 2'd2;
            start = 1;
            @(negedge clk);
            start = 0;
            for (int i = 0; i < 100 && seen < 2; i++) begin
                @(negedge clk);
                if (sa_in_valid) seen++;
            end
            @(negedge clk);
            chk("pre_rst in_addr", in_addr, 1);
            #1 rst = 1;
            #1;
            chk("rst_mid ceb", {in_ceb, w_ceb, out_ceb}, 3'b111);
            chk("rst_mid web", {in_web, w_web, out_web}, 3'b111);
            chk("rst_mid busy", busy, 0);
            chk("rst_mid addrs", {in_addr, w_addr, out_addr}, 0);
            @(negedge clk);
            rst = 0;
        end
        run_check(2'd0, "post_rst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
